izhikevich_array: RTL
=====================

Name: izhikevich_array

Overview:
Time-multiplexed bank of NUM_NEURONS Izhikevich neurons sharing one fixed-point update datapath. Each start pulse performs one Euler step for every neuron in index order, one neuron per clock. Adds per-neuron input currents, a refractory period, saturating arithmetic, a spike bitmap and a state readback port. Sits under the network layer, which drives currents and consumes spike bitmaps.

Parameters:
N, 16, total word width (two's complement fixed point)
Q, 6, fractional bits
NUM_NEURONS, 8, neurons in bank (>=2)
REFRACT, 2, sweeps a neuron is held at c after a spike (0 = no refractory period)
IDX_W, $clog2(NUM_NEURONS), index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin one sweep; honoured only when busy=0
i_wr_en  in  1  write one input current
i_wr_idx  in  IDX_W  current write index
i_wr_data  in  N  current value
v_init, w_init  in  N each  reset values loaded into every neuron
v_th, step, a, b, c, d  in  N each  shared model constants, sampled every cycle
busy  out  1  sweep in progress
done  out  1  one-cycle pulse when sweep completes
spikes  out  NUM_NEURONS  bit k = neuron k spiked in last completed sweep
rd_idx  in  IDX_W  readback index
rd_v, rd_w  out  N each  state of neuron rd_idx, registered (1-cycle latency)

Behaviour:
- Reset (sync, high): all v<=v_init, w<=w_init, currents<=0, refractory counters<=0; busy=0, done=0, spikes=0, rd_v=rd_w=0. Reset during a sweep aborts it, no done pulse.
- FSM: IDLE -> (start) SWEEP -> DONE -> IDLE. start while busy ignored.
- IDLE: start sets busy=1, ptr=0, clears spike accumulator.
- SWEEP: cycle k processes neuron ptr=k (read-modify-write same cycle); after ptr=NUM_NEURONS-1 go DONE.
- DONE: spikes<=accumulator, done=1 for one cycle, busy=0 this cycle. Start-to-done latency = NUM_NEURONS+1 cycles; next start accepted the cycle done is high (back-to-back sweeps every NUM_NEURONS+1 cycles).
- Per neuron, priority order:
  1. refr>0: v<=c, w<=w+dw, refr<=refr-1, no spike.
  2. v>v_th (signed, strict): v<=c, w<=w+d, refr<=REFRACT, spike bit set.
  3. else v<=v+dv, w<=w+dw.
- dv = step*(0.04v^2 + 5v + 140 - w + i); dw = step*a*(b*v - w); all constants in Q format; products truncated toward -inf after shifting right Q.
- Every add/multiply result saturates to [-2^(N-1), 2^(N-1)-1]; no wrap-around.
- Current writes accepted any cycle incl. reset-free sweep; i_wr to neuron being processed that same cycle: old current used, new value stored. Writes to index >= NUM_NEURONS ignored.
- Readback: rd_v/rd_w show state at rd_idx as of previous cycle; out-of-range index returns 0.
- Model constants changed mid-sweep affect only neurons processed afterward.

Decomposition:
- Shared package izh_pkg: fixed-point saturation limits, Q-format constants 0.04/5/140, FSM state enum (ST_IDLE, ST_SWEEP, ST_DONE).
- One sub-module izh_update: combinational v,w,i,refr,constants -> next v,w,refr,spike; reusable by future cores.
- Top holds register files, pointer, FSM, readback.

Test Plan:
- Reset with v_init=-65.0, w_init=-13.0 -> every rd_v=0xEFC0, rd_w=0xFCC0, spikes=0, busy=0.
- All i=0, one start -> busy high 8 cycles, done at cycle 9, spikes=0, states match golden Euler model bit-exact.
- i_wr idx3 = 10.0, loop sweeps until spikes[3]=1 -> rd_v(3)=c, rd_w(3)=old w+d; next 2 sweeps v stays c, spikes[3]=0.
- Drive i=127.0 on neuron 0 -> v saturates at 0x7FFF, never wraps negative.
- Assert rst at cycle 4 of a sweep -> no done, all states = init next cycle; start pulsed while busy -> ignored (single done).
- i_wr to neuron 5 during the cycle it is processed -> old current used this sweep, new current used next sweep.

Source files
------------

// File: rtl/izh_pkg.sv
// ============================================================================
// Module  : izh_pkg
// Brief   : Shared fixed-point helpers and FSM encoding for the Izhikevich bank
// Rev     : 1.0
// ============================================================================
`default_nettype none

package izh_pkg;

    localparam int IZH_N_DEF = 16;
    localparam int IZH_Q_DEF = 6;

    typedef logic [1:0] izh_state_t;
    localparam izh_state_t ST_IDLE  = 2'd0;
    localparam izh_state_t ST_SWEEP = 2'd1;
    localparam izh_state_t ST_DONE  = 2'd2;

    // num/den in Q-format, rounded to nearest (0.04 -> 3 at Q=6)
    function automatic int izh_qconst(input int num, input int den, input int q);
        return (num * (2 ** q) + den / 2) / den;
    endfunction

    function automatic longint izh_sat_hi(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic longint izh_sat_lo(input int n);
        return -izh_sat_hi(n) - 64'sd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/izh_update.sv
// ============================================================================
// Module  : izh_update
// Brief   : Combinational Euler step of one Izhikevich neuron, saturating
// Rev     : 1.0
// ============================================================================
`default_nettype none

module izh_update
    import izh_pkg::*;
#(
    parameter int N       = 16,
    parameter int Q       = 6,
    parameter int REFRACT = 2,
    parameter int RW      = 2
) (
    input  logic signed [N-1:0] i_v,
    input  logic signed [N-1:0] i_w,
    input  logic signed [N-1:0] i_cur,
    input  logic        [RW-1:0] i_refr,
    input  logic signed [N-1:0] i_v_th,
    input  logic signed [N-1:0] i_step,
    input  logic signed [N-1:0] i_a,
    input  logic signed [N-1:0] i_b,
    input  logic signed [N-1:0] i_c,
    input  logic signed [N-1:0] i_d,
    output logic signed [N-1:0] o_v,
    output logic signed [N-1:0] o_w,
    output logic        [RW-1:0] o_refr,
    output logic                o_spike
);

    typedef logic signed [2*N:0] wide_t;

    localparam wide_t c_HI = wide_t'(izh_sat_hi(N));
    localparam wide_t c_LO = wide_t'(izh_sat_lo(N));
    localparam logic signed [N-1:0] c_K004 = N'(izh_qconst(4, 100, Q));
    localparam logic signed [N-1:0] c_K5   = N'(izh_qconst(5, 1, Q));
    localparam logic signed [N-1:0] c_K140 = N'(izh_qconst(140, 1, Q));

    function automatic logic signed [N-1:0] f_sat(input wide_t x);
        if (x > c_HI)
            return c_HI[N-1:0];
        else if (x < c_LO)
            return c_LO[N-1:0];
        else
            return x[N-1:0];
    endfunction

    function automatic logic signed [N-1:0] f_add(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        return f_sat(wide_t'(a) + wide_t'(b));
    endfunction

    function automatic logic signed [N-1:0] f_sub(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        return f_sat(wide_t'(a) - wide_t'(b));
    endfunction

    // Arithmetic shift floors the product before it is clamped
    function automatic logic signed [N-1:0] f_mul(input logic signed [N-1:0] a, input logic signed [N-1:0] b);
        wide_t p;
        p = wide_t'(a) * wide_t'(b);
        return f_sat(p >>> Q);
    endfunction

    logic signed [N-1:0] w_quad;
    logic signed [N-1:0] w_lin;
    logic signed [N-1:0] w_sum;
    logic signed [N-1:0] w_dv;
    logic signed [N-1:0] w_dw;
    logic signed [N-1:0] w_v_euler;
    logic signed [N-1:0] w_w_euler;

    assign w_quad    = f_mul(f_mul(c_K004, i_v), i_v);
    assign w_lin     = f_mul(c_K5, i_v);
    assign w_sum     = f_add(f_sub(f_add(f_add(w_quad, w_lin), c_K140), i_w), i_cur);
    assign w_dv      = f_mul(i_step, w_sum);
    assign w_dw      = f_mul(i_step, f_mul(i_a, f_sub(f_mul(i_b, i_v), i_w)));
    assign w_v_euler = f_add(i_v, w_dv);
    assign w_w_euler = f_add(i_w, w_dw);

    always_comb begin
        o_v     = w_v_euler;
        o_w     = w_w_euler;
        o_refr  = i_refr;
        o_spike = 1'b0;
        if (i_refr != '0) begin
            o_v    = i_c;
            o_refr = i_refr - 1'b1;
        end else if (i_v > i_v_th) begin
            o_v     = i_c;
            o_w     = f_add(i_w, i_d);
            o_refr  = RW'(REFRACT);
            o_spike = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/izhikevich_array.sv
// ============================================================================
// Module  : izhikevich_array
// Brief   : Time-multiplexed Izhikevich neuron bank, one neuron per clock
// Rev     : 1.0
// ============================================================================
`default_nettype none

module izhikevich_array
    import izh_pkg::*;
#(
    parameter int N           = IZH_N_DEF,
    parameter int Q           = IZH_Q_DEF,
    parameter int NUM_NEURONS = 8,
    parameter int REFRACT     = 2,
    parameter int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   i_wr_en,
    input  logic [IDX_W-1:0]       i_wr_idx,
    input  logic signed [N-1:0]    i_wr_data,
    input  logic signed [N-1:0]    v_init,
    input  logic signed [N-1:0]    w_init,
    input  logic signed [N-1:0]    v_th,
    input  logic signed [N-1:0]    step,
    input  logic signed [N-1:0]    a,
    input  logic signed [N-1:0]    b,
    input  logic signed [N-1:0]    c,
    input  logic signed [N-1:0]    d,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_NEURONS-1:0] spikes,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic signed [N-1:0]    rd_v,
    output logic signed [N-1:0]    rd_w
);

    localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

    logic signed [N-1:0]    r_v    [NUM_NEURONS];
    logic signed [N-1:0]    r_w    [NUM_NEURONS];
    logic signed [N-1:0]    r_cur  [NUM_NEURONS];
    logic [RW-1:0]          r_refr [NUM_NEURONS];
    izh_state_t             r_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [NUM_NEURONS-1:0] r_acc;
    logic [NUM_NEURONS-1:0] r_spikes;
    logic signed [N-1:0]    r_rd_v;
    logic signed [N-1:0]    r_rd_w;

    logic                   w_wr_ok;
    logic                   w_rd_ok;
    logic signed [N-1:0]    w_v_nxt;
    logic signed [N-1:0]    w_w_nxt;
    logic [RW-1:0]          w_refr_nxt;
    logic                   w_spike;
    logic [NUM_NEURONS-1:0] w_acc_nxt;

    generate
        if ((2 ** IDX_W) == NUM_NEURONS) begin : g_idx_full
            assign w_wr_ok = i_wr_en;
            assign w_rd_ok = 1'b1;
        end else begin : g_idx_partial
            assign w_wr_ok = i_wr_en && (int'(i_wr_idx) < NUM_NEURONS);
            assign w_rd_ok = (int'(rd_idx) < NUM_NEURONS);
        end
    endgenerate

    izh_update #(
        .N       (N),
        .Q       (Q),
        .REFRACT (REFRACT),
        .RW      (RW)
    ) u_update (
        .i_v     (r_v[r_ptr]),
        .i_w     (r_w[r_ptr]),
        .i_cur   (r_cur[r_ptr]),
        .i_refr  (r_refr[r_ptr]),
        .i_v_th  (v_th),
        .i_step  (step),
        .i_a     (a),
        .i_b     (b),
        .i_c     (c),
        .i_d     (d),
        .o_v     (w_v_nxt),
        .o_w     (w_w_nxt),
        .o_refr  (w_refr_nxt),
        .o_spike (w_spike)
    );

    always_comb begin
        w_acc_nxt        = r_acc;
        w_acc_nxt[r_ptr] = w_spike;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                r_v[k]    <= v_init;
                r_w[k]    <= w_init;
                r_cur[k]  <= '0;
                r_refr[k] <= '0;
            end
            r_state  <= ST_IDLE;
            r_ptr    <= '0;
            r_acc    <= '0;
            r_spikes <= '0;
            r_rd_v   <= '0;
            r_rd_w   <= '0;
        end else begin
            // The datapath already captured the old current for this cycle
            if (w_wr_ok)
                r_cur[i_wr_idx] <= i_wr_data;
            r_rd_v <= w_rd_ok ? r_v[rd_idx] : '0;
            r_rd_w <= w_rd_ok ? r_w[rd_idx] : '0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_state <= ST_IDLE;
                    if (start) begin
                        r_state <= ST_SWEEP;
                        r_ptr   <= '0;
                        r_acc   <= '0;
                    end
                end
                ST_SWEEP: begin
                    r_v[r_ptr]    <= w_v_nxt;
                    r_w[r_ptr]    <= w_w_nxt;
                    r_refr[r_ptr] <= w_refr_nxt;
                    r_acc         <= w_acc_nxt;
                    r_ptr         <= r_ptr + 1'b1;
                    if (r_ptr == IDX_W'(NUM_NEURONS - 1)) begin
                        r_state  <= ST_DONE;
                        r_spikes <= w_acc_nxt;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = (r_state == ST_SWEEP);
    assign done   = (r_state == ST_DONE);
    assign spikes = r_spikes;
    assign rd_v   = r_rd_v;
    assign rd_w   = r_rd_w;

endmodule

`default_nettype wire
